// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe: valid/ready pipelined A-B-Bin from WIDTH/4 CLA slices; ports clk, rst_n, in_valid/in_ready, A, B, Bin, out_valid/out_ready, Diff, Bout, Ovf, Zero
module cla_subtractor_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);
    localparam int STAGES = WIDTH / 4;
    localparam logic [STAGES-1:0] FULL = '1;

    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] p, g, c;
        logic c4;
        p = a ^ ~b;
        g = a & ~b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c[3], p ^ c};
    endfunction

    logic [STAGES-1:0] v, adv, sv, sc, nc, c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  d_r [STAGES];
    logic [WIDTH-1:0]  sa [STAGES];
    logic [WIDTH-1:0]  sb [STAGES];
    logic [WIDTH-1:0]  sd [STAGES];
    logic [WIDTH-1:0]  nd [STAGES];
    logic              nm, bo, ov, z;

    always_comb begin
        nm = 1'b0;
        for (int k = 0; k < STAGES; k++)
            adv[k] = out_ready | ((v >> k) != (FULL >> k));
        sa[0] = A;
        sb[0] = B;
        sd[0] = '0;
        sc[0] = ~Bin;
        sv[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            sa[k] = a_r[k-1];
            sb[k] = b_r[k-1];
            sd[k] = d_r[k-1];
            sc[k] = c_r[k-1];
            sv[k] = v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nd[k] = sd[k];
            {nc[k], nm, nd[k][4*k +: 4]} = cla4(sa[k][4*k +: 4], sb[k][4*k +: 4], sc[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            c_r <= '0;
            bo <= 1'b0;
            ov <= 1'b0;
            z <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                d_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= sv[k];
                    if (sv[k]) begin
                        a_r[k] <= sa[k];
                        b_r[k] <= sb[k];
                        d_r[k] <= nd[k];
                        c_r[k] <= nc[k];
                    end
                end
            end
            if (adv[STAGES-1] && sv[STAGES-1]) begin
                bo <= ~nc[STAGES-1];
                ov <= nm ^ nc[STAGES-1];
                z <= ~|nd[STAGES-1];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign Diff      = d_r[STAGES-1];
    assign Bout      = bo;
    assign Ovf       = ov;
    assign Zero      = z;
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// tb_cla_subtractor_pipe: vector table, stall/reset sequences and random scoreboard for cla_subtractor_pipe
module tb_cla_subtractor_pipe;
    localparam int W = 16;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, Bin = 1'b0;
    logic out_valid, out_ready = 1'b0, Bout, Ovf, Zero;
    logic [W-1:0] A = '0, B = '0, Diff;
    int checks = 0, errors = 0, n_in = 0, n_out = 0;

    typedef struct packed {logic [W-1:0] d; logic bo; logic ov; logic z;} res_t;
    typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic bin; res_t r;} vec_t;

    res_t q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    cla_subtractor_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        res_t r;
        int s, u;
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        u = int'(a) - int'(b) - int'(bin);
        r.d = W'(u);
        r.bo = u < 0;
        r.ov = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
        r.z = W'(u) == '0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input vec_t vv, output int lat);
        out_ready = 1'b1;
        A = vv.a;
        B = vv.b;
        Bin = vv.bin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            if (out_valid) lat = n;
            else step();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Bin));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out got Diff=%h want no result", Diff);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("sb_diff", 32'(Diff), 32'(e.d));
                    chk("sb_bout", 32'(Bout), 32'(e.bo));
                    chk("sb_ovf", 32'(Ovf), 32'(e.ov));
                    chk("sb_zero", 32'(Zero), 32'(e.z));
                end
            end
        end
    end

    initial begin
        int lat, i, low, ovc, stale, base, base_in;
        logic [W-1:0] sd;
        logic sbo, sov, sz;
        tbl[0] = {16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
        tbl[1] = {16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = {16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = {16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[4] = {16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = {16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[6] = {16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        tbl[7] = {16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0};

        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(Diff), 0);
        chk("rst_bout", 32'(Bout), 0);
        chk("rst_ovf", 32'(Ovf), 0);
        chk("rst_zero", 32'(Zero), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(in_ready), 1);

        for (int k = 0; k < 8; k++) begin
            one(tbl[k], lat);
            chk("vec_latency", 32'(lat), 4);
            chk("vec_diff", 32'(Diff), 32'(tbl[k].r.d));
            chk("vec_bout", 32'(Bout), 32'(tbl[k].r.bo));
            chk("vec_ovf", 32'(Ovf), 32'(tbl[k].r.ov));
            chk("vec_zero", 32'(Zero), 32'(tbl[k].r.z));
            step();
        end

        out_ready = 1'b0;
        i = 0;
        base = n_out;
        sd = '0;
        sbo = 1'b0;
        sov = 1'b0;
        sz = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            A = W'(i * 'h1111);
            B = W'(i);
            Bin = i[0];
            if (c == 4) begin
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("accepts_until_full", 32'(i), 4);
                sd = Diff;
                sbo = Bout;
                sov = Ovf;
                sz = Zero;
            end
            if (c == 5) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_diff", 32'(Diff), 32'(sd));
                chk("stall_bout", 32'(Bout), 32'(sbo));
                chk("stall_ovf", 32'(Ovf), 32'(sov));
                chk("stall_zero", 32'(Zero), 32'(sz));
            end
            if (in_ready) i++;
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && i < 8; c++) begin
            in_valid = 1'b1;
            A = W'(i * 'h1111);
            B = W'(i);
            Bin = i[0];
            if (in_ready) i++;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && n_out - base < 8; c++) step();
        chk("stall_results", 32'(n_out - base), 8);

        low = 0;
        ovc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
            if (!in_ready) low++;
            if (c >= 4 && out_valid) ovc++;
            step();
        end
        in_valid = 1'b0;
        chk("full_rate_ready", 32'(low), 0);
        chk("full_rate_out", 32'(ovc), 16);
        for (int c = 0; c < 40 && n_out != n_in; c++) step();

        base_in = n_in;
        for (int c = 0; c < 20000 && n_in - base_in < 2000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n_out != n_in; c++) step();
        chk("random_accepted", 32'(n_in - base_in), 2000);
        chk("in_eq_out", 32'(n_out), 32'(n_in));

        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            A = W'(16'h1234 + c);
            B = 16'h0001;
            Bin = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_diff", 32'(Diff), 0);
        chk("midrst_bout", 32'(Bout), 0);
        chk("midrst_ovf", 32'(Ovf), 0);
        chk("midrst_zero", 32'(Zero), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) stale++;
            step();
        end
        chk("no_stale", 32'(stale), 0);
        one(tbl[0], lat);
        chk("post_rst_latency", 32'(lat), 4);
        chk("post_rst_diff", 32'(Diff), 32'(tbl[0].r.d));
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_subtractor_pipe.md
Name: cla_subtractor_pipe

Overview:
Pipelined N-bit subtractor computing Diff = A - B - Bin, built as WIDTH/4 chained 4-bit carry-look-ahead slices. Each slice evaluates in its own pipeline stage. Subtraction is performed as A + ~B + ~Bin; borrow is the inverted carry.
Sits downstream of operand sources as the inverse datapath to the team's CLA adder. Uses valid/ready handshakes on both sides so it can be dropped between buffered stages.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
STAGES, WIDTH/4, derived (localparam), number of 4-bit slices and pipeline stages.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept an operand beat this cycle.
A  input  WIDTH  minuend (unsigned or two's complement).
B  input  WIDTH  subtrahend.
Bin  input  1  borrow in.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts the result beat.
Diff  output  WIDTH  A - B - Bin mod 2^WIDTH.
Bout  output  1  unsigned borrow out; 1 iff A < B + Bin.
Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB of A + ~B + ~Bin.
Zero  output  1  Diff == 0.

Behaviour:
- Reset (async assert, sync deassert done externally): all stage valid bits are 0, out_valid=0, Diff=0, Bout=0, Ovf=0, Zero=0. in_ready=1 in the cycle after reset.
- Slice k (k=0..STAGES-1) operates on bits [4k+3:4k].
- Per bit: p=a^~b, g=a&~b. Slice carries use full look-ahead: c1=g0|p0c0, c2=g1|p1g0|p1p0c0, and likewise up to c4.
- Slice 0 carry-in is ~Bin. Slice k carry-in is the registered c4 of slice k-1.
- Stage k registers:
  - slice-k sum bits;
  - the accumulated lower result bits;
  - the untouched upper operand bits (skewed forward);
  - the slice carry-out;
  - for the last slice, the carry into the MSB;
  - a valid bit.
- Outputs:
  - Bout = ~c_out(final).
  - Ovf = c_msb_in ^ c_out(final).
  - Zero is computed from the completed Diff in the final stage register.
  - All outputs are driven directly from final-stage registers; no combinational path from A/B to outputs.
- Latency: a beat accepted in cycle t (in_valid & in_ready) appears with out_valid=1 in cycle t+STAGES, if unstalled.
- Throughput: one beat per cycle when out_ready=1.
- Pipeline control:
  - Stage k advances when it is empty or stage k+1 advances; the final stage advances when !out_valid | out_ready.
  - in_ready = !valid0 | advance0. Bubbles collapse.
  - Holding capacity is STAGES beats. in_ready drops only when all stages are full and out_ready=0.
- Output stability: while out_valid=1 and out_ready=0, Diff/Bout/Ovf/Zero are held stable.
- Ordering: results emerge in acceptance order; no drops, no duplicates.
- Data gating: operand inputs are ignored when in_valid=0 or in_ready=0. A stall must not corrupt in-flight data.
- Simultaneous accept and emit in the same cycle with a full pipe is legal; the occupancy count is unchanged.
- Reset mid-operation: all in-flight beats are discarded, and the block returns to the reset state immediately on rst_n low.
- Boundary examples:
  - A=B, Bin=0 gives Diff=0, Zero=1, Bout=0.
  - A=0, B=2^WIDTH-1, Bin=1 gives Diff=0, Zero=1, Bout=1.

Test Plan:
- WIDTH=16, rst released, beat A=0x1234 B=0x0034 Bin=0 at cycle t -> out_valid at t+4, Diff=0x1200, Bout=0, Ovf=0, Zero=0.
- A=0x0000 B=0x0001 Bin=0 -> Diff=0xFFFF, Bout=1, Ovf=0, Zero=0. Then A=0x8000 B=0x0001 Bin=0 -> Diff=0x7FFF, Bout=0, Ovf=1.
- A=0x00FF B=0x00FE Bin=1 -> Diff=0x0000, Zero=1, Bout=0, Ovf=0. Then A=0x0000 B=0xFFFF Bin=1 -> Diff=0x0000, Zero=1, Bout=1.
- 8 back-to-back beats (A=i*0x1111, B=i, Bin=i[0]) with out_ready held 0 for 6 cycles:
  - in_ready falls after 4 accepts;
  - outputs stay stable while stalled;
  - all 8 results emerge in order with correct values once out_ready=1;
  - a full-rate stream then sustains 1 result/cycle.
- 2000 random beats with random in_valid/out_ready -> every result matches a reference model (A-B-Bin, Bout, Ovf, Zero). Count in equals count out.
- Assert rst_n=0 for one cycle with 3 beats in flight:
  - out_valid=0 and outputs zero immediately;
  - no stale beat ever appears after release;
  - next accepted beat has latency 4.
